// File: rtl/portal_request_mux.sv
// portal_request_mux: per-channel say() FIFOs, round-robin merged into one tagged pipe message stream.
// Define PORTAL_REQUEST_MUX_DROP_CNT_EN to build the saturating refused-call cycle counter.
module portal_request_mux #(
  parameter int NCHAN  = 4,
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NCHAN-1:0]        say__ENA,
  input  logic [NCHAN*DATA_W-1:0] say_meth,
  input  logic [NCHAN*DATA_W-1:0] say_v,
  output logic [NCHAN-1:0]        say__RDY,
  output logic                    pipe_enq__ENA,
  output logic [2*DATA_W+31:0]    pipe_enq_v,
  input  logic                    pipe_enq__RDY,
  output logic [15:0]             drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;
  typedef logic [CW-1:0] chan_t;

  localparam cnt_t  FULL = cnt_t'(DEPTH);
  localparam chan_t LAST = chan_t'(NCHAN - 1);

  logic [2*DATA_W-1:0] mem [NCHAN][DEPTH];
  ptr_t                wr_ptr [NCHAN];
  ptr_t                rd_ptr [NCHAN];
  cnt_t                count  [NCHAN];
  logic [15:0]         seq    [NCHAN];
  chan_t               rr_ptr;
  logic [NCHAN-1:0]    push;
  logic [NCHAN-1:0]    pop;
  logic [NCHAN-1:0]    nonempty;
  logic                out_free;
  logic                found;
  chan_t               grant;
  chan_t               idx;

  // Ready comes from the registered count only, so a full FIFO never takes a call even if it pops this cycle.
  always_comb begin
    say__RDY = '0;
    nonempty = '0;
    for (int i = 0; i < NCHAN; i++) begin
      say__RDY[i] = !RST && (count[i] != FULL);
      nonempty[i] = (count[i] != '0);
    end
  end

  assign push     = say__ENA & say__RDY;
  assign out_free = !pipe_enq__ENA || pipe_enq__RDY;

  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 1; k <= NCHAN; k++) begin
      idx = chan_t'((int'(rr_ptr) + k) % NCHAN);
      if (!found && nonempty[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  always_comb begin
    pop = '0;
    if (out_free && found) pop[grant] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NCHAN; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
        seq[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NCHAN; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + ptr_t'(1);
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + ptr_t'(1);
          seq[i]    <= seq[i] + 16'd1;
        end
        count[i] <= count[i] + cnt_t'(push[i]) - cnt_t'(pop[i]);
      end
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the counts above.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NCHAN; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= {say_meth[i*DATA_W +: DATA_W], say_v[i*DATA_W +: DATA_W]};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pipe_enq__ENA <= 1'b0;
      pipe_enq_v    <= '0;
      rr_ptr        <= LAST;
    end else if (out_free) begin
      pipe_enq__ENA <= found;
      if (found) begin
        pipe_enq_v <= {16'(grant), seq[grant], mem[grant][rd_ptr[grant]]};
        rr_ptr     <= grant;
      end
    end
  end

`ifdef PORTAL_REQUEST_MUX_DROP_CNT_EN
  logic [15:0] drop_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      drop_q <= '0;
    end else if ((|(say__ENA & ~say__RDY)) && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_count = drop_q;
`else
  assign drop_count = 16'h0;
`endif

endmodule

// File: tb/tb_portal_request_mux.sv
// Self-checking bench for portal_request_mux: scenario tasks plus random traffic against a queue-based model.
module tb_portal_request_mux;

  localparam int NCHAN  = 4;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int MSG_W  = 2*DATA_W + 32;
  localparam int OBS_W  = 1 + MSG_W + NCHAN + 16;
`ifdef PORTAL_REQUEST_MUX_DROP_CNT_EN
  localparam logic [15:0] EXP_DROP = 16'd1;
`else
  localparam logic [15:0] EXP_DROP = 16'd0;
`endif

  logic                    CLK = 1'b0;
  logic                    RST = 1'b0;
  logic [NCHAN-1:0]        say_ena = '0;
  logic [NCHAN*DATA_W-1:0] say_meth = '0;
  logic [NCHAN*DATA_W-1:0] say_v = '0;
  logic [NCHAN-1:0]        say_rdy;
  logic                    pipe_ena;
  logic [MSG_W-1:0]        pipe_v;
  logic                    pipe_rdy = 1'b0;
  logic [15:0]             drop_count;

  int checks = 0;
  int errors = 0;

  // Reference model: one queue of pending calls per channel, plus the output register contents.
  logic [2*DATA_W-1:0] mq [NCHAN][$];
  logic [15:0]         m_seq [NCHAN];
  int                  m_rr;
  logic                m_ena;
  logic [MSG_W-1:0]    m_v;
  logic [15:0]         m_drop;

  portal_request_mux #(.NCHAN(NCHAN), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .say__ENA      (say_ena),
    .say_meth      (say_meth),
    .say_v         (say_v),
    .say__RDY      (say_rdy),
    .pipe_enq__ENA (pipe_ena),
    .pipe_enq_v    (pipe_v),
    .pipe_enq__RDY (pipe_rdy),
    .drop_count    (drop_count)
  );

  initial forever #5 CLK = ~CLK;

  task automatic model_clear();
    for (int i = 0; i < NCHAN; i++) begin
      mq[i].delete();
      m_seq[i] = 16'd0;
    end
    m_rr   = NCHAN - 1;
    m_ena  = 1'b0;
    m_v    = '0;
    m_drop = 16'd0;
  endtask

  task automatic model_step();
    bit [NCHAN-1:0] can;
    int c;
    for (int i = 0; i < NCHAN; i++) can[i] = (mq[i].size() < DEPTH);
`ifdef PORTAL_REQUEST_MUX_DROP_CNT_EN
    if (((say_ena & ~can) != '0) && (m_drop != 16'hFFFF)) m_drop++;
`endif
    if (!m_ena || pipe_rdy) begin
      m_ena = 1'b0;
      for (int k = 1; k <= NCHAN; k++) begin
        c = (m_rr + k) % NCHAN;
        if (mq[c].size() > 0) begin
          m_v = {16'(c), m_seq[c], mq[c].pop_front()};
          m_seq[c]++;
          m_rr  = c;
          m_ena = 1'b1;
          break;
        end
      end
    end
    for (int i = 0; i < NCHAN; i++) begin
      if (say_ena[i] && can[i]) mq[i].push_back({say_meth[i*DATA_W +: DATA_W], say_v[i*DATA_W +: DATA_W]});
    end
  endtask

  function automatic logic [OBS_W-1:0] exp_obs();
    logic [NCHAN-1:0] r;
    for (int i = 0; i < NCHAN; i++) r[i] = !RST && (mq[i].size() < DEPTH);
    return {m_ena, m_ena ? m_v : {MSG_W{1'b0}}, r, m_drop};
  endfunction

  function automatic logic [OBS_W-1:0] dut_obs();
    return {pipe_ena, pipe_ena ? pipe_v : {MSG_W{1'b0}}, say_rdy, drop_count};
  endfunction

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    say_ena  = '0;
    say_meth = '0;
    say_v    = '0;
  endtask

  task automatic drive_call(input int ch, input logic [31:0] meth, input logic [31:0] v);
    say_ena[ch] = 1'b1;
    say_meth[ch*DATA_W +: DATA_W] = meth;
    say_v[ch*DATA_W +: DATA_W]    = v;
  endtask

  task automatic apply_reset();
    clear_inputs();
    pipe_rdy = 1'b0;
    RST = 1'b1;
    model_clear();
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    model_clear();
    RST = 1'b0;
    #1 RST = 1'b1;
    #1;
    checks++; if (say_rdy !== '0) begin errors++; $display("[TB] FAIL reset_rdy_low got %b expected %b", say_rdy, 4'b0000); end
    checks++; if (pipe_ena !== 1'b0) begin errors++; $display("[TB] FAIL reset_ena got %b expected 0", pipe_ena); end
    checks++; if (pipe_v !== '0) begin errors++; $display("[TB] FAIL reset_v got %h expected 0", pipe_v); end
    checks++; if (drop_count !== 16'h0) begin errors++; $display("[TB] FAIL reset_drop got %h expected 0", drop_count); end
    @(posedge CLK);
    #1 RST = 1'b0;
    #1;
    checks++; if (say_rdy !== 4'b1111) begin errors++; $display("[TB] FAIL reset_rdy_high got %b expected 1111", say_rdy); end
    for (int cyc = 0; cyc < 3; cyc++) begin
      tick();
      checks++; if (dut_obs() !== exp_obs()) begin errors++; $display("[TB] FAIL obs_idle cycle %0d got %h expected %h", cyc, dut_obs(), exp_obs()); end
    end
  endtask

  task automatic test_single_call();
    apply_reset();
    pipe_rdy = 1'b1;
    drive_call(2, 32'h5, 32'hDEADBEEF);
    tick();
    clear_inputs();
    checks++; if (pipe_ena !== 1'b0) begin errors++; $display("[TB] FAIL single_cycle1_ena got %b expected 0", pipe_ena); end
    tick();
    checks++; if (pipe_ena !== 1'b1) begin errors++; $display("[TB] FAIL single_cycle2_ena got %b expected 1", pipe_ena); end
    checks++; if (pipe_v !== {16'd2, 16'd0, 32'h5, 32'hDEADBEEF}) begin
      errors++; $display("[TB] FAIL single_msg got %h expected %h", pipe_v, {16'd2, 16'd0, 32'h5, 32'hDEADBEEF});
    end
    tick();
    checks++; if (pipe_ena !== 1'b0) begin errors++; $display("[TB] FAIL single_cycle3_ena got %b expected 0", pipe_ena); end
    checks++; if (dut_obs() !== exp_obs()) begin errors++; $display("[TB] FAIL obs_single got %h expected %h", dut_obs(), exp_obs()); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < NCHAN; c++) drive_call(c, $urandom, $urandom);
      tick();
      checks++; if (dut_obs() !== exp_obs()) begin errors++; $display("[TB] FAIL obs_rr_load %0d got %h expected %h", r, dut_obs(), exp_obs()); end
    end
    clear_inputs();
    tick();
    pipe_rdy = 1'b1;
    for (int n = 0; n < 2*NCHAN; n++) begin
      checks++;
      if (pipe_ena !== 1'b1 || pipe_v[MSG_W-1 -: 16] !== 16'(n % NCHAN) || pipe_v[MSG_W-17 -: 16] !== 16'(n / NCHAN)) begin
        errors++;
        $display("[TB] FAIL rr_order msg %0d got ena %b chan %0d seq %0d expected ena 1 chan %0d seq %0d",
                 n, pipe_ena, pipe_v[MSG_W-1 -: 16], pipe_v[MSG_W-17 -: 16], n % NCHAN, n / NCHAN);
      end
      tick();
      checks++; if (dut_obs() !== exp_obs()) begin errors++; $display("[TB] FAIL obs_rr msg %0d got %h expected %h", n, dut_obs(), exp_obs()); end
    end
    checks++; if (pipe_ena !== 1'b0) begin errors++; $display("[TB] FAIL rr_drained_ena got %b expected 0", pipe_ena); end
  endtask

  task automatic test_backpressure_full();
    logic [MSG_W-1:0] held;
    int n_ch1;
    apply_reset();
    drive_call(0, $urandom, $urandom);
    tick();
    clear_inputs();
    tick();
    held = pipe_v;
    checks++; if (pipe_ena !== 1'b1) begin errors++; $display("[TB] FAIL bp_preload_ena got %b expected 1", pipe_ena); end
    for (int i = 0; i < 5; i++) begin
      drive_call(1, $urandom, $urandom);
      tick();
      checks++; if (dut_obs() !== exp_obs()) begin errors++; $display("[TB] FAIL obs_bp push %0d got %h expected %h", i, dut_obs(), exp_obs()); end
      checks++; if (pipe_v !== held) begin errors++; $display("[TB] FAIL bp_hold push %0d got %h expected %h", i, pipe_v, held); end
      if (i == 3) begin
        checks++; if (say_rdy[1] !== 1'b0) begin errors++; $display("[TB] FAIL bp_full_rdy got %b expected 0", say_rdy[1]); end
      end
    end
    clear_inputs();
    checks++; if (drop_count !== EXP_DROP) begin errors++; $display("[TB] FAIL bp_drop got %0d expected %0d", drop_count, EXP_DROP); end
    pipe_rdy = 1'b1;
    n_ch1 = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (pipe_ena && pipe_v[MSG_W-1 -: 16] == 16'd1) begin
        checks++; if (pipe_v[MSG_W-17 -: 16] !== 16'(n_ch1)) begin
          errors++; $display("[TB] FAIL bp_ch1_seq got %0d expected %0d", pipe_v[MSG_W-17 -: 16], n_ch1);
        end
        n_ch1++;
      end
      tick();
      checks++; if (dut_obs() !== exp_obs()) begin errors++; $display("[TB] FAIL obs_bp_drain cycle %0d got %h expected %h", cyc, dut_obs(), exp_obs()); end
    end
    checks++; if (n_ch1 != 4) begin errors++; $display("[TB] FAIL bp_ch1_count got %0d expected 4", n_ch1); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int c = 0; c < NCHAN; c++) begin
        if ($urandom_range(0, 2) == 0) drive_call(c, $urandom, $urandom);
        else say_ena[c] = 1'b0;
      end
      pipe_rdy = ($urandom_range(0, 3) != 0) && !((cyc % 100) >= 60 && (cyc % 100) < 80);
      tick();
      checks++; if (dut_obs() !== exp_obs()) begin errors++; $display("[TB] FAIL obs_random cycle %0d got %h expected %h", cyc, dut_obs(), exp_obs()); end
    end
    clear_inputs();
    pipe_rdy = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick();
      checks++; if (dut_obs() !== exp_obs()) begin errors++; $display("[TB] FAIL obs_random_drain cycle %0d got %h expected %h", cyc, dut_obs(), exp_obs()); end
    end
  endtask

  task automatic test_seq_wrap();
    int sent;
    int got;
    apply_reset();
    pipe_rdy = 1'b1;
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 65600 && got < 65537; cyc++) begin
      clear_inputs();
      if (sent < 65537) begin
        drive_call(0, $urandom, $urandom);
        if (mq[0].size() < DEPTH) sent++;
      end
      if (pipe_ena) begin
        if (got == 65535) begin
          checks++; if (pipe_v[MSG_W-17 -: 16] !== 16'hFFFF) begin errors++; $display("[TB] FAIL wrap_seq_last got %h expected ffff", pipe_v[MSG_W-17 -: 16]); end
        end
        if (got == 65536) begin
          checks++; if (pipe_v[MSG_W-17 -: 16] !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_seq_zero got %h expected 0000", pipe_v[MSG_W-17 -: 16]); end
        end
        got++;
      end
      tick();
      checks++; if (dut_obs() !== exp_obs()) begin errors++; $display("[TB] FAIL obs_wrap cycle %0d got %h expected %h", cyc, dut_obs(), exp_obs()); end
    end
    clear_inputs();
    checks++; if (got != 65537) begin errors++; $display("[TB] FAIL wrap_msg_count got %0d expected 65537", got); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive_call(3, $urandom, $urandom);
      tick();
      checks++; if (dut_obs() !== exp_obs()) begin errors++; $display("[TB] FAIL obs_mid_load %0d got %h expected %h", i, dut_obs(), exp_obs()); end
    end
    clear_inputs();
    checks++; if (pipe_ena !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre_ena got %b expected 1", pipe_ena); end
    #3 RST = 1'b1;
    #1;
    checks++; if (pipe_ena !== 1'b0) begin errors++; $display("[TB] FAIL mid_async_ena got %b expected 0", pipe_ena); end
    checks++; if (say_rdy !== '0) begin errors++; $display("[TB] FAIL mid_rdy got %b expected 0000", say_rdy); end
    model_clear();
    @(posedge CLK);
    #1 RST = 1'b0;
    pipe_rdy = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      tick();
      checks++; if (pipe_ena !== 1'b0) begin errors++; $display("[TB] FAIL mid_stale cycle %0d got %b expected 0", cyc, pipe_ena); end
    end
    drive_call(3, 32'hA5, 32'h12345678);
    tick();
    clear_inputs();
    tick();
    checks++; if (pipe_ena !== 1'b1 || pipe_v !== {16'd3, 16'd0, 32'hA5, 32'h12345678}) begin
      errors++; $display("[TB] FAIL mid_first_msg got ena %b v %h expected ena 1 v %h", pipe_ena, pipe_v, {16'd3, 16'd0, 32'hA5, 32'h12345678});
    end
  endtask

  initial begin
    $display("[TB] starting portal_request_mux bench");
    test_reset();
    test_single_call();
    test_round_robin();
    test_backpressure_full();
    test_random();
    test_reset_mid();
    test_seq_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/portal_request_mux.md
Name: portal_request_mux

Overview:
- N-channel successor to the single-channel request/indication wiring.
- Accepts `say(meth, v)` method calls on NCHAN independent channels and buffers each in a per-channel FIFO of DEPTH entries.
- Round-robin arbitrates the channels and serialises each call into one tagged pipe message for a single downstream `enq` consumer.
- Sits between Echo-style user logic and the portal transport. It replaces one output adapter per interface with a single shared adapter.

Parameters:
- NCHAN, 4, number of request channels (2..16).
- DEPTH, 4, entries per channel FIFO (power of two, >=2).
- DATA_W, 32, width of meth and v. Message width MSG_W = 2*DATA_W + 32.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  reset, asynchronous, active-high.
- say__ENA  input  NCHAN  per-channel call strobe.
- say_meth  input  NCHAN*DATA_W  channel i at [i*DATA_W +: DATA_W].
- say_v  input  NCHAN*DATA_W  channel i at [i*DATA_W +: DATA_W].
- say__RDY  output  NCHAN  channel i FIFO not full.
- pipe_enq__ENA  output  1  message valid.
- pipe_enq_v  output  MSG_W  message: {chan[15:0], seq[15:0], meth, v}, chan in the MSBs.
- pipe_enq__RDY  input  1  downstream accepts.
- drop_count  output  16  see Optional Feature.

Behaviour:
- Reset (asynchronous, while RST high):
  - All FIFOs emptied, all 16-bit per-channel seq counters cleared to 0.
  - Round-robin pointer = NCHAN-1, so channel 0 has first priority.
  - pipe_enq__ENA=0, pipe_enq_v=0, drop_count=0.
  - say__RDY = all ones from the first cycle after RST deasserts. It reads 0 while RST is high.
  - Reset mid-transfer discards every buffered and in-flight message with no partial output.
- Push:
  - say__RDY[i] = (count_i != DEPTH), registered-count based.
  - No pass-through when full: a push is never accepted while full, even if a pop occurs that cycle.
  - A call is accepted on an edge where say__ENA[i] && say__RDY[i].
  - say__ENA[i] with say__RDY[i]=0 is ignored; the FIFO is unchanged.
  - All channels may push in the same cycle.
- Output register (one stage):
  - The register is free when pipe_enq__ENA=0, or when pipe_enq__ENA && pipe_enq__RDY (drain and refill in the same cycle, full throughput).
  - When free and any FIFO is non-empty, grant the first non-empty channel searching from pointer+1 modulo NCHAN.
  - On grant: pop that FIFO, load the register with {grant, seq_grant, meth, v}, increment seq_grant (wraps 0xFFFF->0), set pointer = grant.
  - When free and all FIFOs are empty, pipe_enq__ENA clears to 0.
  - pipe_enq_v is held stable while pipe_enq__ENA && !pipe_enq__RDY.
- Latency: say__ENA in cycle 0 with the mux idle gives pipe_enq__ENA=1 in cycle 2.
- Throughput: one message per cycle while pipe_enq__RDY=1 and work is pending.
- Simultaneous push and pop on one channel is allowed when not full; count is unchanged.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- Per-channel order is preserved. Fairness: with all channels backlogged, each channel is served exactly once per NCHAN grants.

Optional Feature:
- Macro: PORTAL_REQUEST_MUX_DROP_CNT_EN.
- Defined:
  - drop_count increments on every cycle in which any bit of (say__ENA & ~say__RDY) is set. It counts +1 per cycle, not per channel.
  - drop_count saturates at 0xFFFF and clears only on reset.
- Undefined: drop_count is tied to 16'h0 and no counter logic is built.

Test Plan:
- Reset then idle: RST pulse, hold -> say__RDY=4'b1111, pipe_enq__ENA=0, drop_count=0.
- Single call: ch2 say(meth=0x5, v=0xDEADBEEF) in cycle 0, pipe_enq__RDY=1 -> cycle 2 pipe_enq_v = {16'd2, 16'd0, 32'h5, 32'hDEADBEEF}, ENA high exactly one cycle.
- Round-robin: preload 2 calls on each of ch0..ch3, then pipe_enq__RDY=1 -> channel order 0,1,2,3,0,1,2,3; seq 0 for the first four messages, then 1 for the next four; 8 consecutive valid cycles.
- Backpressure and full: pipe_enq__RDY=0, push 5 calls on ch1 -> say__RDY[1] drops after the 4th accepted push; the 5th is ignored (drop_count=1 with macro, 0 without). pipe_enq_v stays stable. Release RDY -> exactly 4 ch1 messages, seq 0..3.
- Seq wrap: 65537 calls on ch0 -> the last two messages carry seq 0xFFFF then 0x0000.
- Reset mid-operation: RST asserted with ch3 holding 3 entries and pipe_enq__ENA=1 -> ENA falls asynchronously. After release: no stale messages, and the next ch3 message carries seq 0.
